// File: rtl/release_delay.sv
// Asymmetric level filter: out asserts one cycle after in rises, is held for a
// minimum on-time, and releases only after a run of consecutive low samples.
module release_delay #(
   parameter logic INIT        = 1'b0,
   parameter int   NBITS       = 4,
   parameter int   MIN_ON_BITS = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic in,
   output logic out,
   output logic busy,
   output logic rise,
   output logic fall
);

   localparam int CW = (NBITS > MIN_ON_BITS) ? NBITS : MIN_ON_BITS;

   typedef enum logic [1:0] {
      S_OFF      = 2'd0,
      S_MIN_HOLD = 2'd1,
      S_ON       = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   localparam state_t RST_STATE = INIT ? S_ON : S_OFF;

   // Declaration initialisers give the same power-up state as a reset.
   state_t        r_state = RST_STATE;
   logic [CW-1:0] r_cnt   = '0;
   logic          r_out   = INIT;
   logic          r_busy  = 1'b0;
   logic          r_rise  = 1'b0;
   logic          r_fall  = 1'b0;

   logic w_min_done;
   logic w_rel_done;
   logic w_cnt_sat;

   assign w_min_done = &r_cnt[MIN_ON_BITS-1:0];
   assign w_rel_done = &r_cnt[NBITS-1:0];
   assign w_cnt_sat  = &r_cnt;

   // NOTE: every register here is updated with <= so all reads see the
   // pre-edge values, regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= RST_STATE;
         r_cnt   <= '0;
         r_out   <= INIT;
         r_busy  <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            S_OFF: begin
               if (in) begin
                  r_state <= S_MIN_HOLD;
                  r_cnt   <= '0;
                  r_out   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_rise  <= 1'b1;
               end
            end
            S_MIN_HOLD: begin
               // Minimum on-time runs to completion whatever in does.
               if (w_min_done) begin
                  r_cnt <= '0;
                  if (in) begin
                     r_state <= S_ON;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_RELEASE;
                     r_busy  <= 1'b1;
                  end
               end else if (!w_cnt_sat) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_ON: begin
               if (!in) begin
                  r_state <= S_RELEASE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_RELEASE: begin
               if (in) begin
                  r_state <= S_ON;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else if (w_rel_done) begin
                  r_state <= S_OFF;
                  r_cnt   <= '0;
                  r_out   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_fall  <= 1'b1;
               end else if (!w_cnt_sat) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_OFF;
               r_cnt   <= '0;
               r_out   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign out  = r_out;
   assign busy = r_busy;
   assign rise = r_rise;
   assign fall = r_fall;

endmodule

// File: tb/tb_release_delay.sv
// Directed bench for release_delay: a vector table for the basic sequence plus
// hand-written sequences for release timing, pulse stretching and mid-count reset.
module tb_release_delay;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_l = 1'b0;

   logic out0, busy0, rise0, fall0;
   logic out1, busy1, rise1, fall1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   release_delay #(.INIT(1'b0), .NBITS(4), .MIN_ON_BITS(2)) dut0 (
      .CLK(clk), .RST(rst), .in(in_l),
      .out(out0), .busy(busy0), .rise(rise0), .fall(fall0)
   );

   release_delay #(.INIT(1'b1), .NBITS(4), .MIN_ON_BITS(2)) dut1 (
      .CLK(clk), .RST(rst), .in(in_l),
      .out(out1), .busy(busy1), .rise(rise1), .fall(fall1)
   );

   typedef struct {
      bit         rst;
      bit         in;
      logic [3:0] exp;   // {out, busy, rise, fall}
      string      name;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got {out,busy,rise,fall}=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit i);
      @(negedge clk);
      rst  = r;
      in_l = i;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] o0();
      return {out0, busy0, rise0, fall0};
   endfunction

   function automatic logic [3:0] o1();
      return {out1, busy1, rise1, fall1};
   endfunction

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 4'b0000, "reset"};
      vecs[1]  = '{1'b0, 1'b0, 4'b0000, "idle_low_1"};
      vecs[2]  = '{1'b0, 1'b0, 4'b0000, "idle_low_2"};
      vecs[3]  = '{1'b0, 1'b0, 4'b0000, "idle_low_3"};
      vecs[4]  = '{1'b0, 1'b1, 4'b1110, "assert_rise"};
      vecs[5]  = '{1'b0, 1'b1, 4'b1100, "min_hold_1"};
      vecs[6]  = '{1'b0, 1'b1, 4'b1100, "min_hold_2"};
      vecs[7]  = '{1'b0, 1'b1, 4'b1100, "min_hold_3"};
      vecs[8]  = '{1'b0, 1'b1, 4'b1000, "enter_on"};
      vecs[9]  = '{1'b0, 1'b1, 4'b1000, "stay_on"};
      vecs[10] = '{1'b0, 1'b0, 4'b1100, "enter_release"};
      vecs[11] = '{1'b0, 1'b1, 4'b1000, "back_to_on"};

      // Power-up values before any clock edge.
      #1;
      check("powerup_init0", o0(), 4'b0000);
      check("powerup_init1", o1(), 4'b1000);

      for (int i = 0; i < 12; i++) begin
         step(vecs[i].rst, vecs[i].in);
         check(vecs[i].name, o0(), vecs[i].exp);
         if (i == 0) begin
            check("reset_init1", o1(), 4'b1000);
         end
      end

      // From ON: 16 low samples keep out high, the 17th releases it.
      for (int k = 1; k <= 16; k++) begin
         step(1'b0, 1'b0);
         check($sformatf("release_low_%0d", k), o0(), 4'b1100);
      end
      step(1'b0, 1'b0);
      check("release_fall", o0(), 4'b0001);
      step(1'b0, 1'b0);
      check("after_fall", o0(), 4'b0000);

      // Single-cycle pulse from OFF: out high for 4 + 16 = 20 cycles.
      for (int k = 0; k < 24; k++) begin
         logic [3:0] e;
         step(1'b0, (k == 0));
         e = {(k < 20), (k < 20), (k == 0), (k == 20)};
         check($sformatf("pulse_%0d", k), o0(), e);
      end

      // Into ON, then low 10, high 1, and a fresh run of 17 lows.
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1);
      check("glitch_on", o0(), 4'b1000);
      for (int k = 1; k <= 10; k++) begin
         step(1'b0, 1'b0);
         check($sformatf("glitch_low_%0d", k), o0(), 4'b1100);
      end
      step(1'b0, 1'b1);
      check("glitch_high", o0(), 4'b1000);
      for (int k = 1; k <= 16; k++) begin
         step(1'b0, 1'b0);
         check($sformatf("glitch_relow_%0d", k), o0(), 4'b1100);
      end
      step(1'b0, 1'b0);
      check("glitch_fall", o0(), 4'b0001);

      // Reset on the 8th low edge of RELEASE, both INIT values.
      step(1'b1, 1'b0);
      check("mid_rst_pre_init0", o0(), 4'b0000);
      check("mid_rst_pre_init1", o1(), 4'b1000);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1);
      check("mid_rst_on_init0", o0(), 4'b1000);
      check("mid_rst_on_init1", o1(), 4'b1000);
      for (int k = 1; k <= 7; k++) step(1'b0, 1'b0);
      check("mid_rst_release_init0", o0(), 4'b1100);
      check("mid_rst_release_init1", o1(), 4'b1100);
      step(1'b1, 1'b0);
      check("mid_rst_abort_init0", o0(), 4'b0000);
      check("mid_rst_abort_init1", o1(), 4'b1000);
      total++;
      if (int'(dut1.r_state) != 2) begin
         bad++;
         $display("FAIL mid_rst_state_init1: got state=%0d expected 2 (ON)", int'(dut1.r_state));
      end
      step(1'b0, 1'b0);
      check("post_rst_init0", o0(), 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/release_delay.md
RELEASE_DELAY -- requirements
Module: release_delay

Interface
REQ-001 SHALL have parameter INIT, default 1'b0, which sets the value of out at power-up and after reset.
REQ-002 SHALL have parameter NBITS, default 4, the release counter width; NBITS >= 1.
REQ-003 SHALL have parameter MIN_ON_BITS, default 2, the minimum-on counter width; MIN_ON_BITS >= 1.
REQ-004 SHALL have port CLK  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in  input  1  level to be filtered.
REQ-007 SHALL have port out  output  1  registered filtered level: asserts fast, releases slowly.
REQ-008 SHALL have port busy  output  1  registered; high while the block is in MIN_HOLD or RELEASE.
REQ-009 SHALL have port rise  output  1  registered one-cycle strobe, high on the cycle out first reads 1.
REQ-010 SHALL have port fall  output  1  registered one-cycle strobe, high on the cycle out first reads 0.

Function
REQ-011 SHALL implement a four-state FSM: OFF (out=0), MIN_HOLD (out=1), ON (out=1), RELEASE (out=1).
REQ-012 SHALL use a single counter of width max(NBITS, MIN_ON_BITS) that saturates by compare and never wraps.
REQ-013 SHALL, in OFF with in=1 on an edge, move to MIN_HOLD, set out=1, pulse rise, and clear the counter on that same edge (1-cycle assert latency).
REQ-014 SHALL, in OFF with in=0, hold all outputs at 0.
REQ-015 SHALL, in MIN_HOLD, count every edge regardless of in; when counter[MIN_ON_BITS-1:0] is all ones, go to ON if in=1, otherwise to RELEASE, and clear the counter.
REQ-016 SHALL, in ON with in=0, go to RELEASE and clear the counter; with in=1, stay in ON.
REQ-017 SHALL, in RELEASE with in=1, go to ON and clear the counter; the release count is not retained.
REQ-018 SHALL, in RELEASE with in=0 and counter[NBITS-1:0] all ones, go to OFF, set out=0, and pulse fall; otherwise it increments the counter.
REQ-019 SHALL deassert out after the last of 2**NBITS+1 consecutive low samples of in, counting the first sample taken in ON.
REQ-020 SHALL hold out=1 for at least 2**MIN_ON_BITS+1 cycles after any assertion; a 1-cycle input pulse from OFF yields out high for exactly 2**MIN_ON_BITS + 2**NBITS cycles.
REQ-021 SHALL keep rise and fall high for exactly one cycle, never both in the same cycle, and aligned with the edge on which out changes.
REQ-022 SHALL drive busy=1 exactly while the state is MIN_HOLD or RELEASE.

Reset
REQ-023 SHALL give RST priority over all other inputs.
REQ-024 SHALL, on RST, set the state to ON if INIT=1 and to OFF if INIT=0, and set out=INIT.
REQ-025 SHALL, on RST, set the counter, busy, rise and fall to 0.
REQ-026 SHALL, when RST is asserted mid-RELEASE or mid-MIN_HOLD, abort the count; out goes to INIT on that edge with no rise or fall strobe.
REQ-027 SHALL use the same power-up register values as the reset values.

Verification (NBITS=4, MIN_ON_BITS=2 unless stated)
REQ-028 SHALL cover: RST, in=0 -> out=0, busy=0, rise=0, fall=0 on every following cycle.
REQ-029 SHALL cover: in held 1 from edge 10 -> out=1 and rise=1 after edge 10; busy=1 after edges 10..13; busy=0 and state ON after edge 14.
REQ-030 SHALL cover: from ON, in low for 16 edges -> out stays 1; on the 17th low edge out=0 and fall=1 for one cycle.
REQ-031 SHALL cover: from ON, in low 10 edges, high 1 edge, then low -> out stays 1 throughout; out falls only after 17 further consecutive low edges.
REQ-032 SHALL cover: in a 1-cycle pulse from OFF -> out high for exactly 20 cycles, rise at the start, fall at the end, busy high for all 20.
REQ-033 SHALL cover: RST asserted on the 8th low edge of RELEASE, INIT=0 -> out=0 on that edge with fall=0; repeat with INIT=1 -> out=1, busy=0, and state ON.
